// File: rtl/hmmm_loader_if.sv
// Program/IO bus bundle between the hmmm_loader and its surroundings.
//
// Host byte stream:  in_data, in_valid (to loader), in_ready (from loader).
// Core bus:          read, write, halt, bus_i (to loader);
//                    cpu_rst, pgrm_addr, pgrm_data, bus_o, bus_oe (from loader).
// Status:            out_data, out_valid, rd_full, done (from loader).
//
// Modports:
//   master - host/core side that drives the byte stream and the core requests.
//   slave  - the loader itself.
interface hmmm_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cpu_rst;
    logic        pgrm_addr;
    logic        pgrm_data;
    logic        read;
    logic        write;
    logic        halt;
    logic [15:0] bus_i;
    logic [15:0] bus_o;
    logic        bus_oe;
    logic [15:0] out_data;
    logic        out_valid;
    logic        rd_full;
    logic        done;

    modport master (
        output in_data, in_valid, read, write, halt, bus_i,
        input  in_ready, cpu_rst, pgrm_addr, pgrm_data, bus_o, bus_oe,
               out_data, out_valid, rd_full, done
    );

    modport slave (
        input  in_data, in_valid, read, write, halt, bus_i,
        output in_ready, cpu_rst, pgrm_addr, pgrm_data, bus_o, bus_oe,
               out_data, out_valid, rd_full, done
    );
endinterface

// File: rtl/hmmm_loader.sv
// Host-side front end for the hmmm core.
//
// Loads a program image from a byte stream (header byte = word count - 1,
// then each word high byte first) by sequencing the core's pgrm_addr /
// pgrm_data strobes, holds the core in reset for RST_CYCLES cycles, then
// services the core's read/write bus cycles until it reports halt.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   ldr  - hmmm_loader_if.slave: host byte stream, core bus, status outputs
//
// Parameter:
//   RST_CYCLES - cycles cpu_rst stays high after the last word (1..15)
module hmmm_loader #(
    parameter int unsigned RST_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    hmmm_loader_if.slave   ldr
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W_HI = 3'd1,
        ST_W_LO = 3'd2,
        ST_ADDR = 3'd3,
        ST_DATA = 3'd4,
        ST_CRST = 3'd5,
        ST_RUN  = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    state_t      state_r;
    logic [7:0]  count_r;      // word count minus one (the header byte)
    logic [7:0]  addr_r;
    logic [15:0] word_r;
    logic [3:0]  crst_cnt_r;
    logic        cpu_rst_r;
    logic        pgrm_addr_r;
    logic        pgrm_data_r;
    logic        bus_oe_r;
    logic [15:0] bus_o_r;
    logic [7:0]  rd_hi_r;      // high byte held until the low byte arrives
    logic        rd_phase_r;   // 1: high byte of the host word already taken
    logic [15:0] rd_word_r;
    logic        rd_full_r;
    logic        write_d_r;
    logic [15:0] out_data_r;
    logic        out_valid_r;
    logic        done_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        run_read_s;

    // Byte acceptance window decoded from state; held low while in reset.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_W_HI, ST_W_LO, ST_RUN, ST_DONE: in_ready_s = rst;
            default:                                    in_ready_s = 1'b0;
        endcase
    end

    assign accept_s   = ldr.in_valid & in_ready_s;
    // Core reads are answered in the same cycle, so the read path bypasses the registers.
    assign run_read_s = (state_r == ST_RUN) & ldr.read;

    // Load/run sequencer with registered strobes and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            count_r     <= 8'h00;
            addr_r      <= 8'h00;
            word_r      <= 16'h0000;
            crst_cnt_r  <= 4'd0;
            cpu_rst_r   <= 1'b1;
            pgrm_addr_r <= 1'b0;
            pgrm_data_r <= 1'b0;
            bus_oe_r    <= 1'b0;
            bus_o_r     <= 16'h0000;
            rd_hi_r     <= 8'h00;
            rd_phase_r  <= 1'b0;
            rd_word_r   <= 16'h0000;
            rd_full_r   <= 1'b0;
            write_d_r   <= 1'b0;
            out_data_r  <= 16'h0000;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            // Tracked in every state so a write already high when RUN starts is not an edge.
            write_d_r   <= ldr.write;
            case (state_r)
                ST_IDLE: begin
                    cpu_rst_r <= 1'b1;
                    if (accept_s) begin
                        count_r   <= ldr.in_data;
                        addr_r    <= 8'h00;
                        cpu_rst_r <= 1'b0;
                        state_r   <= ST_W_HI;
                    end
                end
                ST_W_HI: begin
                    if (accept_s) begin
                        word_r[15:8] <= ldr.in_data;
                        state_r      <= ST_W_LO;
                    end
                end
                ST_W_LO: begin
                    if (accept_s) begin
                        word_r[7:0] <= ldr.in_data;
                        pgrm_addr_r <= 1'b1;
                        bus_oe_r    <= 1'b1;
                        bus_o_r     <= {8'h00, addr_r};
                        state_r     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    pgrm_addr_r <= 1'b0;
                    pgrm_data_r <= 1'b1;
                    bus_o_r     <= word_r;
                    state_r     <= ST_DATA;
                end
                ST_DATA: begin
                    pgrm_data_r <= 1'b0;
                    bus_oe_r    <= 1'b0;
                    bus_o_r     <= 16'h0000;
                    if (addr_r == count_r) begin
                        cpu_rst_r  <= 1'b1;
                        crst_cnt_r <= 4'(RST_CYCLES - 32'd1);
                        state_r    <= ST_CRST;
                    end else begin
                        addr_r  <= addr_r + 8'd1;
                        state_r <= ST_W_HI;
                    end
                end
                ST_CRST: begin
                    if (crst_cnt_r == 4'd0) begin
                        cpu_rst_r <= 1'b0;
                        state_r   <= ST_RUN;
                    end else begin
                        crst_cnt_r <= crst_cnt_r - 4'd1;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (rd_phase_r) begin
                            rd_word_r  <= {rd_hi_r, ldr.in_data};
                            rd_phase_r <= 1'b0;
                        end else begin
                            rd_hi_r    <= ldr.in_data;
                            rd_phase_r <= 1'b1;
                        end
                    end
                    // A completing word wins over a simultaneous read.
                    if (accept_s && rd_phase_r) begin
                        rd_full_r <= 1'b1;
                    end else if (ldr.read) begin
                        rd_full_r <= 1'b0;
                    end
                    if (ldr.write && !write_d_r) begin
                        out_data_r  <= ldr.bus_i;
                        out_valid_r <= 1'b1;
                    end
                    if (ldr.halt) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Any byte here is the header of a fresh image.
                    if (accept_s) begin
                        count_r    <= ldr.in_data;
                        addr_r     <= 8'h00;
                        done_r     <= 1'b0;
                        rd_phase_r <= 1'b0;
                        rd_full_r  <= 1'b0;
                        state_r    <= ST_W_HI;
                    end
                end
                default: begin
                    cpu_rst_r   <= 1'b1;
                    pgrm_addr_r <= 1'b0;
                    pgrm_data_r <= 1'b0;
                    bus_oe_r    <= 1'b0;
                    bus_o_r     <= 16'h0000;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ldr.in_ready  = in_ready_s;
    assign ldr.cpu_rst   = cpu_rst_r;
    assign ldr.pgrm_addr = pgrm_addr_r;
    assign ldr.pgrm_data = pgrm_data_r;
    assign ldr.bus_oe    = bus_oe_r | run_read_s;
    assign ldr.bus_o     = run_read_s ? rd_word_r : bus_o_r;
    assign ldr.out_data  = out_data_r;
    assign ldr.out_valid = out_valid_r;
    assign ldr.rd_full   = rd_full_r;
    assign ldr.done      = done_r;

endmodule

// File: tb/tb_hmmm_loader.sv
// Self-checking bench for hmmm_loader: a cycle-timeline model derived from
// accepted host bytes and core requests, plus directed literal checks.
module tb_hmmm_loader;

    localparam int RST = 1;

    logic clk = 1'b0;
    logic rst;

    hmmm_loader_if ldr ();

    hmmm_loader #(.RST_CYCLES(RST)) dut (
        .clk (clk),
        .rst (rst),
        .ldr (ldr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] img [0:8] = '{16'h1105, 16'h1203, 16'h7312, 16'h6000, 16'hE307,
                               16'h0102, 16'hB008, 16'h0202, 16'h0000};

    logic [15:0] strobe_q [$];   // bus_o seen at each pgrm_addr / pgrm_data
    logic [15:0] ov_q [$];       // out_data seen at each out_valid

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int          cyc, a_cyc, d_cyc, crst_s, crst_e, run_cyc, n_words, k_idx;
    logic [15:0] a_val, d_val, m_rd_word, m_out_data;
    logic [7:0]  m_hi, m_rd_hi;
    bit          idle_m, done_m, load_active, have_hi, crst_valid, run_valid;
    bit          m_rd_phase, m_rd_full, m_ov, write_prev;

    task automatic model_reset();
        a_cyc = -1; d_cyc = -1; crst_s = -1; crst_e = -1; run_cyc = -1;
        n_words = 0; k_idx = 0; a_val = '0; d_val = '0; m_hi = '0;
        m_rd_word = '0; m_rd_hi = '0; m_out_data = '0;
        idle_m = 1; done_m = 0; load_active = 0; have_hi = 0;
        crst_valid = 0; run_valid = 0; m_rd_phase = 0; m_rd_full = 0;
        m_ov = 0; write_prev = 0;
    endtask

    initial begin : compare
        bit exp_pa, exp_pd, in_crst, in_run, exp_ready, exp_oe, acc, lo_acc;
        logic [15:0] exp_bus;
        cyc = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_cpu_rst",   ldr.cpu_rst,   1'b1);
                chk("rst_pgrm_addr", ldr.pgrm_addr, 1'b0);
                chk("rst_pgrm_data", ldr.pgrm_data, 1'b0);
                chk("rst_bus_oe",    ldr.bus_oe,    1'b0);
                chk("rst_bus_o",     ldr.bus_o,     16'h0000);
                chk("rst_out_data",  ldr.out_data,  16'h0000);
                chk("rst_out_valid", ldr.out_valid, 1'b0);
                chk("rst_rd_full",   ldr.rd_full,   1'b0);
                chk("rst_done",      ldr.done,      1'b0);
                chk("rst_in_ready",  ldr.in_ready,  1'b0);
                model_reset();
            end else begin
                exp_pa    = (cyc == a_cyc);
                exp_pd    = (cyc == d_cyc);
                in_crst   = crst_valid && (cyc >= crst_s) && (cyc <= crst_e);
                in_run    = run_valid && (cyc >= run_cyc);
                exp_ready = !(exp_pa || exp_pd || in_crst);
                exp_oe    = exp_pa || exp_pd || (in_run && ldr.read);
                exp_bus   = exp_pa ? a_val : (exp_pd ? d_val : m_rd_word);

                chk("pgrm_addr", ldr.pgrm_addr, exp_pa);
                chk("pgrm_data", ldr.pgrm_data, exp_pd);
                chk("in_ready",  ldr.in_ready,  exp_ready);
                chk("cpu_rst",   ldr.cpu_rst,   idle_m || in_crst);
                chk("bus_oe",    ldr.bus_oe,    exp_oe);
                if (exp_oe) chk("bus_o", ldr.bus_o, exp_bus);
                chk("out_valid", ldr.out_valid, m_ov);
                chk("out_data",  ldr.out_data,  m_out_data);
                chk("rd_full",   ldr.rd_full,   m_rd_full);
                chk("done",      ldr.done,      done_m);

                if (ldr.pgrm_addr) strobe_q.push_back(ldr.bus_o);
                if (ldr.pgrm_data) strobe_q.push_back(ldr.bus_o);
                if (ldr.out_valid) ov_q.push_back(ldr.out_data);

                // advance the model by the inputs sampled at the coming edge
                acc    = ldr.in_valid && exp_ready;
                lo_acc = 0;
                if (acc) begin
                    if (idle_m || done_m) begin
                        n_words = int'(ldr.in_data) + 1;
                        k_idx = 0; have_hi = 0; load_active = 1;
                        if (done_m) begin
                            m_rd_full = 0; m_rd_phase = 0;
                        end
                        idle_m = 0; done_m = 0;
                    end else if (load_active) begin
                        if (!have_hi) begin
                            m_hi = ldr.in_data; have_hi = 1;
                        end else begin
                            have_hi = 0;
                            a_cyc = cyc + 1; a_val = {8'h00, 8'(k_idx)};
                            d_cyc = cyc + 2; d_val = {m_hi, ldr.in_data};
                            if (k_idx == n_words - 1) begin
                                load_active = 0; crst_valid = 1;
                                crst_s = cyc + 3; crst_e = cyc + 2 + RST;
                                run_valid = 1; run_cyc = cyc + 3 + RST;
                            end else begin
                                k_idx++;
                            end
                        end
                    end else if (in_run) begin
                        if (!m_rd_phase) begin
                            m_rd_hi = ldr.in_data; m_rd_phase = 1;
                        end else begin
                            m_rd_word = {m_rd_hi, ldr.in_data}; m_rd_phase = 0; lo_acc = 1;
                        end
                    end
                end
                if (in_run) begin
                    if (lo_acc) m_rd_full = 1;
                    else if (ldr.read) m_rd_full = 0;
                end
                m_ov = in_run && ldr.write && !write_prev;
                if (m_ov) m_out_data = ldr.bus_i;
                if (in_run && ldr.halt) begin
                    done_m = 1; run_valid = 0;
                end
                write_prev = ldr.write;
                cyc++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int max_stall);
        bit ok;
        if (max_stall > 0) begin
            ldr.in_valid = 1'b0;
            repeat ($urandom_range(max_stall)) begin
                @(posedge clk); #1;
            end
        end
        ldr.in_data  = b;
        ldr.in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ldr.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        ldr.in_valid = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] hdr, input int nw, input int stall);
        send_byte(hdr, stall);
        for (int k = 0; k < nw; k++) begin
            send_byte(img[k][15:8], stall);
            send_byte(img[k][7:0], stall);
        end
    endtask

    // Returns at the first negedge of RUN; reports cpu_rst-high cycles seen.
    task automatic wait_run(output int hi);
        bit seen, ok;
        seen = 0; ok = 0; hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ldr.cpu_rst) begin
                seen = 1; hi++;
            end else if (seen) begin
                ok = 1;
                break;
            end
        end
        chk("reach_run", 32'(ok), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int s0, o0, hi, n5;
        bit ok;
        rst = 1'b0;
        ldr.in_data = 8'h00; ldr.in_valid = 1'b0; ldr.read = 1'b0;
        ldr.write = 1'b0; ldr.halt = 1'b0; ldr.bus_i = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_cpu_rst", ldr.cpu_rst, 1'b1);
        chk("t1_in_ready", ldr.in_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t1_idle_ready", ldr.in_ready, 1'b1);
        @(posedge clk); #1;

        // 9-word image, back-to-back
        s0 = strobe_q.size();
        send_image(8'h08, 9, 0);
        wait_run(hi);
        chk("t2_crst_cycles", 32'(hi), 32'(RST));
        chk("t2_strobes", 32'(strobe_q.size() - s0), 32'd18);
        chk("t2_first_addr", strobe_q[s0],      16'h0000);
        chk("t2_first_data", strobe_q[s0 + 1],  16'h1105);
        chk("t2_last_addr",  strobe_q[s0 + 16], 16'h0008);
        chk("t2_last_data",  strobe_q[s0 + 17], 16'h0000);

        // core writes 3 then halts
        @(posedge clk); #1;
        o0 = ov_q.size();
        ldr.bus_i = 16'h0003; ldr.write = 1'b1;
        @(posedge clk); #1;
        ldr.write = 1'b0; ldr.bus_i = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        ldr.halt = 1'b1;
        @(posedge clk); #1;
        ldr.halt = 1'b0;
        @(negedge clk);
        chk("t3_ov_count", 32'(ov_q.size() - o0), 32'd1);
        chk("t3_out_data", ov_q[o0], 16'h0003);
        n5 = 0;
        foreach (ov_q[i]) if (ov_q[i] == 16'h0005) n5++;
        chk("t3_no_5", 32'(n5), 32'd0);
        chk("t3_done", ldr.done, 1'b1);
        chk("t3_in_ready", ldr.in_ready, 1'b1);

        // reload from DONE with random stalls
        @(posedge clk); #1;
        s0 = strobe_q.size();
        send_image(8'h08, 9, 3);
        wait_run(hi);
        chk("t4_crst_cycles", 32'(hi), 32'(RST));
        chk("t4_strobes", 32'(strobe_q.size() - s0), 32'd18);
        for (int k = 0; k < 9; k++) begin
            chk("t4_addr", strobe_q[s0 + 2*k],     {8'h00, 8'(k)});
            chk("t4_data", strobe_q[s0 + 2*k + 1], img[k]);
        end

        // host word read by the core
        @(posedge clk); #1;
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        @(negedge clk);
        chk("t5_rd_full_set", ldr.rd_full, 1'b1);
        @(posedge clk); #1;
        ldr.read = 1'b1;
        @(negedge clk);
        chk("t5_oe_1", ldr.bus_oe, 1'b1);
        chk("t5_bus_1", ldr.bus_o, 16'hABCD);
        @(negedge clk);
        chk("t5_oe_2", ldr.bus_oe, 1'b1);
        chk("t5_bus_2", ldr.bus_o, 16'hABCD);
        @(posedge clk); #1;
        ldr.read = 1'b0;
        @(negedge clk);
        chk("t5_rd_full_clr", ldr.rd_full, 1'b0);
        chk("t5_oe_off", ldr.bus_oe, 1'b0);

        // held write gives a single pulse
        @(posedge clk); #1;
        o0 = ov_q.size();
        ldr.bus_i = 16'h5A5A; ldr.write = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ldr.write = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_ov_count", 32'(ov_q.size() - o0), 32'd1);
        chk("t6_out_data", ldr.out_data, 16'h5A5A);

        // write and halt together
        @(posedge clk); #1;
        ldr.bus_i = 16'h0777; ldr.write = 1'b1; ldr.halt = 1'b1;
        @(posedge clk); #1;
        ldr.write = 1'b0; ldr.halt = 1'b0;
        @(negedge clk);
        chk("t7_out_valid", ldr.out_valid, 1'b1);
        chk("t7_out_data", ldr.out_data, 16'h0777);
        chk("t7_done", ldr.done, 1'b1);

        // reset during DATA of word 3; a write edge outside RUN is ignored
        @(posedge clk); #1;
        send_byte(8'h08, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) ldr.write = 1'b1;
            if (k == 2) ldr.write = 1'b0;
            send_byte(img[k][15:8], 0);
            send_byte(img[k][7:0], 0);
        end
        ok = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ldr.pgrm_data) begin
                ok = 1;
                break;
            end
        end
        chk("t8_word3_data", 32'(ok), 32'd1);
        chk("t8_word3_bus", ldr.bus_o, 16'h6000);
        #2 rst = 1'b0;
        #1;
        chk("t8_async_cpu_rst", ldr.cpu_rst, 1'b1);
        chk("t8_async_pgrm_data", ldr.pgrm_data, 1'b0);
        chk("t8_async_bus_oe", ldr.bus_oe, 1'b0);
        chk("t8_async_in_ready", ldr.in_ready, 1'b0);
        chk("t8_async_done", ldr.done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        s0 = strobe_q.size();
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        wait_run(hi);
        chk("t8_strobes", 32'(strobe_q.size() - s0), 32'd2);
        chk("t8_addr", strobe_q[s0],     16'h0000);
        chk("t8_data", strobe_q[s0 + 1], 16'h1234);
        chk("t8_crst_cycles", 32'(hi), 32'(RST));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hmmm_loader.md
# hmmm_loader

Host-side front end for the `hmmm` core, acting as the other end of its program/IO bus. It accepts a byte stream and sequences the core's `pgrm_addr`/`pgrm_data` strobes to load a program image. It then pulses the core's reset to start execution. While the program runs, it services the core's `read`/`write` bus cycles and reports `halt`.

## Interface
- `RST_CYCLES`, default 1: number of cycles `cpu_rst` is held high after the last word is loaded; legal range 1–15.
- `clk  input  1`: single clock; all logic on the rising edge.
- `rst  input  1`: asynchronous, active-low reset.
- `in_data  input  8`: host byte.
- `in_valid  input  1`: host byte valid.
- `in_ready  output  1`: byte is accepted on a rising edge with `in_valid && in_ready`.
- `cpu_rst  output  1`: active-high reset to the core.
- `pgrm_addr  output  1`: program-address strobe to the core.
- `pgrm_data  output  1`: program-data strobe to the core.
- `read  input  1`: core read request.
- `write  input  1`: core write request.
- `halt  input  1`: core halted.
- `bus_i  input  16`: resolved core bus value.
- `bus_o  output  16`: value this block drives onto the bus.
- `bus_oe  output  1`: bus drive enable; top level builds the tristate.
- `out_data  output  16`: last word written by the core.
- `out_valid  output  1`: one-cycle pulse when `out_data` updates.
- `rd_full  output  1`: a host word is waiting for a core read.
- `done  output  1`: the core has halted.

## Operation
- Image format: first byte is the header, with word count N = header + 1 (1..256). Then N words follow, each as two bytes with the high byte first. Word k loads to address k (0..N-1).
- States:
  - IDLE: `in_ready`=1, `cpu_rst`=1. An accepted header byte latches the count, clears the address counter, and moves to W_HI.
  - W_HI: `in_ready`=1. An accepted byte is stored as bits 15:8 of the word; move to W_LO.
  - W_LO: `in_ready`=1. An accepted byte is stored as bits 7:0; move to ADDR.
  - ADDR: one cycle with `pgrm_addr`=1, `bus_oe`=1, `bus_o`={8'h00, addr}; move to DATA.
  - DATA: one cycle with `pgrm_data`=1, `bus_oe`=1, `bus_o`=word. Then either increment the address and go to W_HI, or go to CRST if the address equals N-1.
  - CRST: `cpu_rst`=1 for `RST_CYCLES` cycles, then RUN.
  - RUN: `cpu_rst`=0. Host bytes are assembled into `rd_word` (high byte first). `rd_full` sets when the low byte is accepted.
    - Core read: while `read`=1, `bus_oe`=1 and `bus_o`=`rd_word` combinationally. `rd_full` clears on any cycle with `read`=1. A read with `rd_full`=0 returns the stale `rd_word`.
    - Core write: on the first cycle of `write`=1 (rising-edge detect), `out_data`←`bus_i` and `out_valid`=1 for one cycle. A held `write` produces one pulse only.
    - `halt`=1 sampled in RUN moves to DONE.
  - DONE: `done`=1, `cpu_rst`=0, `in_ready`=1. An accepted byte is treated as a new header: `done` clears and the block goes to W_HI, which reloads the image.
- `cpu_rst`=0 during W_HI, W_LO, ADDR and DATA.
- `bus_oe`=0 in every state or condition not listed above.
- Simultaneous events:
  - A read in the same cycle the low byte is accepted: the bus shows the old `rd_word`, the new word is latched, and `rd_full` ends at 1.
  - `write` and `halt` in the same cycle: the write is captured, then DONE.
  - A rising edge on `write` during any non-RUN state is ignored.
- Reset asserted mid-load or mid-run: immediately return to IDLE. All partial state is discarded.

## Timing
- Reset values:
  - `cpu_rst`=1.
  - `pgrm_addr`=`pgrm_data`=`bus_oe`=0.
  - `bus_o`=0, `out_data`=0.
  - `out_valid`=`rd_full`=`done`=0.
  - `in_ready`=0 while `rst` is low, then 1 in IDLE.
- All strobes and outputs are registered except `bus_oe`/`bus_o` in RUN (combinational from `read`) and `in_ready` (decoded from state).
- Per-word cost: 4 cycles minimum (two bytes, ADDR, DATA). The ADDR and DATA strobes are each exactly one cycle and back-to-back.
- `in_ready`=0 during ADDR, DATA and CRST.
- The first RUN cycle is `RST_CYCLES`+1 cycles after the final DATA cycle.
- `out_valid` is asserted in the cycle after the `write` rising edge is sampled. `done` is asserted the cycle after `halt` is sampled.

## Test plan
- Load the 9-word image with header 0x08, streamed back-to-back, words 0x1105, 0x1203, 0x7312, 0x6000, 0xE307, 0x0102, 0xB008, 0x0202, 0x0000. Expected:
  - 9 ADDR/DATA pairs.
  - First pair drives `bus_o`=0x0000 then 0x1105; last pair drives 0x0008 then 0x0000.
  - `cpu_rst` pulses for 1 cycle, then RUN.
- Run the loaded image against the `hmmm` core. Expected: exactly one `out_valid` with `out_data`=0x0003, no 0x0005 output, then `done`=1 and `in_ready`=1.
- Stall `in_valid` randomly during the load. Expected: identical strobe sequence; no strobe occurs before both bytes of each word are accepted.
- In RUN, send bytes 0xAB, 0xCD, then assert `read` for 2 cycles. Expected: `rd_full`=1 before the read, `bus_o`=0xABCD with `bus_oe`=1 during the read, and `rd_full`=0 after.
- Drop `rst` low during the DATA cycle of word 3. Expected: outputs return to reset values asynchronously; a fresh header plus 1 word (0x00, 0x12, 0x34) then loads 0x1234 at address 0.
- Hold `write` high for 4 cycles with `bus_i`=0x5A5A. Expected: one `out_valid` pulse, `out_data`=0x5A5A.
